// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and the per-edge action decode for the EX/MEM pipeline register.
package ex_mem_reg_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam int   STALL_EX      = 3;
    localparam int   STALL_MEM     = 4;

    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_ADVANCE = 3'd1,
        OP_BUBBLE  = 3'd2,
        OP_FLUSH   = 3'd3,
        OP_RESET   = 3'd4
    } slot_op_e;

    // stall_mem without stall_ex cannot legally occur; it falls through to advance.
    function automatic slot_op_e decode_op(input logic rst, input logic flush,
                                           input logic stall_ex, input logic stall_mem);
        if (rst == RST_ENABLE)
            return OP_RESET;
        else if (flush)
            return OP_FLUSH;
        else if (stall_ex && !stall_mem)
            return OP_BUBBLE;
        else if (!stall_ex)
            return OP_ADVANCE;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/bubble/flush handling and MADD partial-state feedback.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int STALL_W = 6,
    parameter int BCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [RADDR_W-1:0]  ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [1:0]          cnt_i,
    output logic [RADDR_W-1:0]  mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_valid,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [1:0]          cnt_o,
    output logic [BCNT_W-1:0]   bubble_cnt
);

    slot_op_e op;

    always_comb begin
        op = decode_op(rst, flush, stall[STALL_EX], stall[STALL_MEM]);
    end

    always_ff @(posedge clk) begin
        case (op)
            OP_RESET, OP_FLUSH: begin
                mem_wd      <= '0;
                mem_wreg    <= WRITE_DISABLE;
                mem_wdata   <= '0;
                mem_whilo   <= WRITE_DISABLE;
                mem_hi      <= '0;
                mem_lo      <= '0;
                mem_valid   <= 1'b0;
                hilo_temp_o <= '0;
                cnt_o       <= '0;
            end
            // EX is self-stalling: emit a bubble but keep its multi-cycle state alive.
            OP_BUBBLE: begin
                mem_wd      <= '0;
                mem_wreg    <= WRITE_DISABLE;
                mem_wdata   <= '0;
                mem_whilo   <= WRITE_DISABLE;
                mem_hi      <= '0;
                mem_lo      <= '0;
                mem_valid   <= 1'b0;
                hilo_temp_o <= hilo_temp_i;
                cnt_o       <= cnt_i;
            end
            OP_ADVANCE: begin
                mem_wd      <= ex_wd;
                mem_wreg    <= ex_wreg;
                mem_wdata   <= ex_wdata;
                mem_whilo   <= ex_whilo;
                mem_hi      <= ex_hi;
                mem_lo      <= ex_lo;
                mem_valid   <= 1'b1;
                hilo_temp_o <= '0;
                cnt_o       <= '0;
            end
            default: begin
            end
        endcase
    end

    sat_counter #(
        .W(BCNT_W)
    ) u_bubble (
        .clk   (clk),
        .clr   (rst == RST_ENABLE),
        .inc   (op == OP_BUBBLE),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg with a queue-based scoreboard and monitor.
module tb_ex_mem_reg;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        valid;
        logic [63:0] ht;
        logic [1:0]  cnt;
        logic [15:0] bcnt;
        logic [1:0]  sbcnt;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = 5'd31;
    logic        ex_wreg = 1'b1;
    logic [31:0] ex_wdata = 32'hFFFF_FFFF;
    logic        ex_whilo = 1'b1;
    logic [31:0] ex_hi = 32'hAAAA_AAAA;
    logic [31:0] ex_lo = 32'h5555_5555;
    logic [63:0] hilo_temp_i = 64'hDEAD_BEEF_0000_0001;
    logic [1:0]  cnt_i = 2'd3;

    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, mem_valid;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    logic [4:0]  s_wd;
    logic        s_wreg, s_whilo, s_valid;
    logic [31:0] s_wdata, s_hi, s_lo;
    logic [63:0] s_ht;
    logic [1:0]  s_cnt;
    logic [1:0]  s_bcnt;

    int tests = 0;
    int fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy makes saturation reachable in a few bubbles.
    ex_mem_reg #(.BCNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata), .mem_whilo(s_whilo),
        .mem_hi(s_hi), .mem_lo(s_lo), .mem_valid(s_valid),
        .hilo_temp_o(s_ht), .cnt_o(s_cnt), .bubble_cnt(s_bcnt)
    );

    always @(posedge clk) begin
        assert (!(stall[4] && !stall[3])) else $error("illegal stall vector %b", stall);
    end

    function automatic exp_t mk(input string n, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic whilo,
                                input logic [31:0] hi, input logic [31:0] lo, input logic valid,
                                input logic [63:0] ht, input logic [1:0] cnt,
                                input logic [15:0] bcnt, input logic [1:0] sbcnt);
        exp_t e;
        e.name = n; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo;
        e.hi = hi; e.lo = lo; e.valid = valid; e.ht = ht; e.cnt = cnt;
        e.bcnt = bcnt; e.sbcnt = sbcnt;
        return e;
    endfunction

    task automatic drive(input logic r, input logic f, input logic [5:0] st,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [63:0] ht, input logic [1:0] cnt, input exp_t e);
        @(negedge clk);
        rst = r; flush = f; stall = st;
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_whilo = whilo;
        ex_hi = hi; ex_lo = lo; hilo_temp_i = ht; cnt_i = cnt;
        q.push_back(e);
    endtask

    task automatic chk(input string n, input string field, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", n, field, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "mem_wd",      64'(mem_wd),    64'(e.wd));
            chk(e.name, "mem_wreg",    64'(mem_wreg),  64'(e.wreg));
            chk(e.name, "mem_wdata",   64'(mem_wdata), 64'(e.wdata));
            chk(e.name, "mem_whilo",   64'(mem_whilo), 64'(e.whilo));
            chk(e.name, "mem_hi",      64'(mem_hi),    64'(e.hi));
            chk(e.name, "mem_lo",      64'(mem_lo),    64'(e.lo));
            chk(e.name, "mem_valid",   64'(mem_valid), 64'(e.valid));
            chk(e.name, "hilo_temp_o", hilo_temp_o,    e.ht);
            chk(e.name, "cnt_o",       64'(cnt_o),     64'(e.cnt));
            chk(e.name, "bubble_cnt",  64'(bubble_cnt), 64'(e.bcnt));
            chk(e.name, "sat_bcnt",    64'(s_bcnt),    64'(e.sbcnt));
        end
    end

    localparam logic [5:0] S_RUN   = 6'b000000;
    localparam logic [5:0] S_BUB   = 6'b001111;
    localparam logic [5:0] S_HOLD  = 6'b011111;
    localparam logic [5:0] S_FRONT = 6'b000111;
    localparam logic [63:0] MADD_P = 64'h0000_0001_FFFF_FFFE;

    initial begin
        int budget;
        drive(1, 0, S_RUN, 5'd31, 1, 32'hFFFF_FFFF, 1, 32'hAAAA_AAAA, 32'h5555_5555,
              64'hDEAD_BEEF_0000_0001, 2'd3, mk("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 0, S_BUB, 5'd31, 1, 32'hFFFF_FFFF, 1, 32'hAAAA_AAAA, 32'h5555_5555,
              64'hDEAD_BEEF_0000_0001, 2'd3, mk("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(0, 0, S_RUN, 5'd3, 1, 32'h1234_5678, 0, 0, 0, 64'h0000_0000_0000_BEEF, 2'd2,
              mk("advance", 3, 1, 32'h1234_5678, 0, 0, 0, 1, 0, 0, 0, 0));
        drive(0, 0, S_BUB, 5'd4, 1, 32'h0BAD_0BAD, 0, 0, 0, MADD_P, 2'd1,
              mk("madd_a", 0, 0, 0, 0, 0, 0, 0, MADD_P, 1, 1, 1));
        drive(0, 0, S_RUN, 5'd0, 0, 0, 1, 32'h2, 32'h5, MADD_P, 2'd0,
              mk("madd_b", 0, 0, 0, 1, 32'h2, 32'h5, 1, 0, 0, 1, 1));
        drive(0, 0, S_FRONT, 5'd7, 1, 32'hAABB_CCDD, 0, 0, 0, 0, 2'd0,
              mk("front_stall", 7, 1, 32'hAABB_CCDD, 0, 0, 0, 1, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            drive(0, 0, S_HOLD, 5'd9, 0, 32'h1111_1111, 1, 32'h9, 32'h9, 64'h77, 2'd3,
                  mk("hold", 7, 1, 32'hAABB_CCDD, 0, 0, 0, 1, 0, 0, 1, 1));
        drive(0, 0, S_BUB, 5'd9, 1, 32'h1, 0, 0, 0, 64'h0000_1234_0000_5678, 2'd1,
              mk("bubble2", 0, 0, 0, 0, 0, 0, 0, 64'h0000_1234_0000_5678, 1, 2, 2));
        drive(0, 1, S_BUB, 5'd9, 1, 32'h1, 1, 32'h3, 32'h3, MADD_P, 2'd1,
              mk("flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
        drive(0, 0, S_BUB, 5'd1, 1, 32'h1, 0, 0, 0, 64'h10, 2'd1,
              mk("sat_a", 0, 0, 0, 0, 0, 0, 0, 64'h10, 1, 3, 3));
        drive(0, 0, S_BUB, 5'd1, 1, 32'h1, 0, 0, 0, 64'h20, 2'd2,
              mk("sat_b", 0, 0, 0, 0, 0, 0, 0, 64'h20, 2, 4, 3));
        drive(0, 0, S_BUB, 5'd1, 1, 32'h1, 0, 0, 0, 64'h30, 2'd1,
              mk("sat_c", 0, 0, 0, 0, 0, 0, 0, 64'h30, 1, 5, 3));
        drive(1, 0, S_BUB, 5'd1, 1, 32'h1, 1, 32'h1, 32'h1, 64'h40, 2'd1,
              mk("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(0, 0, S_RUN, 5'd2, 0, 32'hCAFE_F00D, 1, 32'h8, 32'h9, 0, 2'd0,
              mk("post_reset", 2, 0, 32'hCAFE_F00D, 1, 32'h8, 32'h9, 1, 0, 0, 0, 0));
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS32 core.
- Captures EX results: GPR write address/data/enable and HI/LO write enable/values.
- Presents them to MEM one cycle later.
- Implements the stall/bubble/flush protocol of the central stall controller.
- Carries the 64-bit partial result and cycle counter for two-cycle MADD/MADDU/MSUB/MSUBU back to EX.
- Counts inserted bubbles for performance monitoring.

Parameters:
- DATA_W, 32, GPR and HI/LO data width
- RADDR_W, 5, GPR address width
- STALL_W, 6, width of stall vector (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
- BCNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  stall vector from stall controller
- flush  in  1  exception flush; kills the instruction in flight
- ex_wd  in  RADDR_W  EX destination GPR address
- ex_wreg  in  1  EX GPR write enable
- ex_wdata  in  DATA_W  EX GPR write data
- ex_whilo  in  1  EX HI/LO write enable
- ex_hi  in  DATA_W  EX HI value
- ex_lo  in  DATA_W  EX LO value
- hilo_temp_i  in  2*DATA_W  EX multiply-accumulate partial product
- cnt_i  in  2  EX multi-cycle step count
- mem_wd  out  RADDR_W  to MEM: destination address
- mem_wreg  out  1  to MEM: GPR write enable
- mem_wdata  out  DATA_W  to MEM: GPR write data
- mem_whilo  out  1  to MEM: HI/LO write enable
- mem_hi  out  DATA_W  to MEM: HI
- mem_lo  out  DATA_W  to MEM: LO
- mem_valid  out  1  high when the registered slot holds a real instruction
- hilo_temp_o  out  2*DATA_W  back to EX: held partial product
- cnt_o  out  2  back to EX: held step count
- bubble_cnt  out  BCNT_W  saturating count of bubbles inserted

Behaviour:
- All outputs are registers; no combinational path from inputs to outputs.
- Per-edge priority, highest first:
  1. rst=1: all outputs 0 (mem_wd=0, enables=0, data=0, mem_valid=0, hilo_temp_o=0, cnt_o=0, bubble_cnt=0).
  2. flush=1: slot outputs (mem_wd..mem_lo) 0 and mem_valid=0; hilo_temp_o=0, cnt_o=0; bubble_cnt unchanged.
  3. Bubble, stall[3]=1 and stall[4]=0:
     - Slot outputs 0, mem_valid=0.
     - hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, so EX keeps partial state across its self-stall.
     - bubble_cnt increments, saturating at all-ones.
  4. Advance, stall[3]=0: slot outputs load ex_* inputs; mem_valid=1; hilo_temp_o=0, cnt_o=0.
  5. Hold, stall[3]=1 and stall[4]=1: every register keeps its value.
- The "slot outputs" are mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi and mem_lo.
- stall[4]=1 with stall[3]=0 is illegal; the bench asserts it never occurs. RTL treats it as Advance.
- Latency: EX value at edge N appears on mem_* after edge N; one-cycle latency.
- Two-cycle MADD sequence:
  - Cycle A: EX requests stall (stall=6'b001111) and presents cnt_i=1 with the product.
  - Edge: Bubble captures both values.
  - Cycle B: EX sees cnt_o=1 and the partial product, then finishes.
  - Edge: Advance clears cnt_o to 0.
- Flush during a MADD sequence discards the partial product (cnt_o=0).
- Reset mid-sequence behaves as a flush plus a bubble_cnt clear.
- bubble_cnt does not wrap: at 16'hFFFF it stays 16'hFFFF.

Decomposition:
- Shared defines, existing global include: RstEnable, WriteEnable/WriteDisable, ZeroWord, NOPRegAddr, RegBus, RegAddrBus, DoubleRegBus, stall-bit indices STALL_EX=3, STALL_MEM=4.
- Optional sub-module sat_counter (BCNT_W wide, inc/clr, saturating), reusable for other perf counters.

Test Plan:
- rst=1 for 2 cycles with ex_* nonzero -> all outputs 0, bubble_cnt=0.
- stall=0; ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678 -> next cycle mem_wd=3, mem_wreg=1, mem_wdata=32'h12345678, mem_valid=1, cnt_o=0.
- MADD: cycle A stall=6'b001111, cnt_i=1, hilo_temp_i=64'h0000_0001_FFFF_FFFE -> mem_valid=0, mem_wreg=0, cnt_o=1, hilo_temp_o held, bubble_cnt=1. Cycle B stall=0, ex_whilo=1, ex_hi=32'h2 -> mem_whilo=1, mem_hi=2, cnt_o=0.
- Hold: stall=6'b011111 for 3 cycles after a valid load -> mem_* unchanged, bubble_cnt unchanged.
- flush=1 together with stall=6'b001111 and cnt_i=1 -> mem_valid=0, cnt_o=0, hilo_temp_o=0, bubble_cnt unchanged (flush wins).
- Force bubble_cnt to 16'hFFFE, then apply 3 bubbles -> reads 16'hFFFF and stays there.
